// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives start/bin_in and the slave (converter) returns busy/done/result.
interface bin_to_bcd_seq_if #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (output start, bin_in, input busy, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one decimal digit per clock via divide-by-10,
// plus the combinational unsigned/signed divider it is built around.
module div #(
  parameter int a_width  = 8,
  parameter int b_width  = 4,
  parameter int tc_mode  = 0,
  parameter int rem_mode = 1
) (
  input  logic [a_width-1:0] a,
  input  logic [b_width-1:0] b,
  output logic [a_width-1:0] quotient,
  output logic [b_width-1:0] remainder,
  output logic               divide_by_0
);
  logic [a_width-1:0] b_x;
  logic [a_width-1:0] q_raw;
  logic [a_width-1:0] r_raw;
  logic [a_width-1:0] r_fix;

  always_comb begin
    if (tc_mode != 0) b_x = a_width'($signed(b));
    else              b_x = a_width'(b);
    divide_by_0 = (b == '0);
    if (divide_by_0) begin
      q_raw = '1;
      r_raw = a;
    end else if (tc_mode != 0) begin
      q_raw = $signed(a) / $signed(b_x);
      r_raw = $signed(a) % $signed(b_x);
    end else begin
      q_raw = a / b_x;
      r_raw = a % b_x;
    end
    // modulus mode: remainder takes the sign of the divisor
    r_fix = r_raw;
    if ((rem_mode == 0) && (tc_mode != 0) && (r_raw != '0) &&
        (r_raw[a_width-1] != b_x[a_width-1]))
      r_fix = r_raw + b_x;
    quotient  = q_raw;
    remainder = b_width'(r_fix);
  end
endmodule

// state  | meaning
// IDLE   | waiting for start; result held
// DIV    | peeling one digit per clock, units first
// DONE   | one-cycle done pulse; start ignored
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int IDX_W = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   work_q, work_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [IN_WIDTH-1:0]   quot;
  logic [3:0]            rem;
  logic                  div_zero;

  div #(.a_width(IN_WIDTH), .b_width(4), .tc_mode(0), .rem_mode(1)) u_div (
    .a           (work_q),
    .b           (4'd10),
    .quotient    (quot),
    .remainder   (rem),
    .divide_by_0 (div_zero)
  );

  // divisor is the constant 10, so this can only fire on a broken divider
  assert property (@(posedge clk) disable iff (!reset_n) !div_zero);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      idx_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    idx_d   = idx_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = bus.bin_in;
          idx_d   = '0;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IDX_W'(k)) bcd_d[4*k +: 4] = rem;
        end
        work_d = quot;
        idx_d  = idx_q + IDX_W'(1);
        // fixed latency: no early exit when work reaches zero
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          ovf_d   = (quot != '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: three instances (8b/3 digits, 8b/2 digits,
// 16b/5 digits) sharing one clock and reset.
module tb_bin_to_bcd_seq;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  bin_to_bcd_seq_if #(.IN_WIDTH(8),  .DIGITS(3)) if0 ();
  bin_to_bcd_seq_if #(.IN_WIDTH(8),  .DIGITS(2)) if1 ();
  bin_to_bcd_seq_if #(.IN_WIDTH(16), .DIGITS(5)) if2 ();

  bin_to_bcd_seq #(.IN_WIDTH(8),  .DIGITS(3)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  bin_to_bcd_seq #(.IN_WIDTH(8),  .DIGITS(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input int sel, input logic s, input logic [15:0] v);
    case (sel)
      0:       begin if0.start = s; if0.bin_in = v[7:0]; end
      1:       begin if1.start = s; if1.bin_in = v[7:0]; end
      default: begin if2.start = s; if2.bin_in = v;      end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0:       return if0.overflow;
      1:       return if1.overflow;
      default: return if2.overflow;
    endcase
  endfunction

  function automatic logic [19:0] get_bcd(input int sel);
    case (sel)
      0:       return {8'h0, if0.bcd_out};
      1:       return {12'h0, if1.bcd_out};
      default: return if2.bcd_out;
    endcase
  endfunction

  // Pulse start for one edge, then wait (bounded) for done. edges = clock edges
  // after the accepting edge until done is seen; 20 means it never came.
  task automatic run_conv(input int sel, input logic [15:0] v,
                          output int edges, output logic [19:0] bcd, output logic ovf);
    @(negedge clk);
    set_in(sel, 1'b1, v);
    @(negedge clk);
    set_in(sel, 1'b0, 16'hxxxx);
    edges = 0;
    while (!get_done(sel) && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    bcd = get_bcd(sel);
    ovf = get_ovf(sel);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_in(0, 1'b0, 16'h0);
    set_in(1, 1'b0, 16'h0);
    set_in(2, 1'b0, 16'h0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0 || get_bcd(s) !== 20'h0 || get_ovf(s) !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: busy=%b done=%b bcd=%h ovf=%b, required all zero",
                 s, get_busy(s), get_done(s), get_bcd(s), get_ovf(s));
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] vin [4];
    logic [19:0] vexp [4];
    int e; logic [19:0] b; logic o;
    vin  = '{16'd255, 16'd0, 16'd9, 16'd100};
    vexp = '{20'h255, 20'h000, 20'h009, 20'h100};
    for (int i = 0; i < 4; i++) begin
      run_conv(0, vin[i], e, b, o);
      checks++;
      if (b !== vexp[i]) begin
        failures++;
        $display("FAIL basic_bcd[%0d]: got %h required %h", i, b, vexp[i]);
      end
      checks++;
      if (o !== 1'b0) begin
        failures++;
        $display("FAIL basic_ovf[%0d]: got %b required 0", i, o);
      end
      checks++;
      if (e != 3) begin
        failures++;
        $display("FAIL basic_latency[%0d]: got %0d edges required 3", i, e);
      end
    end
  endtask

  task automatic test_overflow();
    int e; logic [19:0] b; logic o;
    run_conv(1, 16'd255, e, b, o);
    checks++;
    if (b !== 20'h55 || o !== 1'b1 || e != 2) begin
      failures++;
      $display("FAIL ovf_255: got bcd=%h ovf=%b edges=%0d required bcd=55 ovf=1 edges=2", b, o, e);
    end
    run_conv(1, 16'd99, e, b, o);
    checks++;
    if (b !== 20'h99 || o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_99: got bcd=%h ovf=%b required bcd=99 ovf=0", b, o);
    end
    run_conv(1, 16'd100, e, b, o);
    checks++;
    if (b !== 20'h00 || o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_100: got bcd=%h ovf=%b required bcd=00 ovf=1", b, o);
    end
  endtask

  task automatic test_back_to_back();
    int pulses; int e;
    @(negedge clk);
    set_in(0, 1'b1, 16'd42);
    @(negedge clk);                       // accepting edge passed
    set_in(0, 1'b1, 16'd7);               // held through DIV and DONE
    checks++;
    if (get_busy(0) !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy: got %b required 1", get_busy(0));
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (get_done(0) === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || get_done(0) !== 1'b1 || get_bcd(0) !== 20'h042) begin
      failures++;
      $display("FAIL b2b_first: got pulses=%0d done=%b bcd=%h required 1/1/042", pulses, get_done(0), get_bcd(0));
    end
    @(negedge clk);                       // DONE -> IDLE, start ignored
    checks++;
    if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b0 || get_bcd(0) !== 20'h042) begin
      failures++;
      $display("FAIL b2b_idle: got done=%b busy=%b bcd=%h required 0/0/042", get_done(0), get_busy(0), get_bcd(0));
    end
    @(negedge clk);                       // accepted in first IDLE cycle
    set_in(0, 1'b0, 16'h0);
    checks++;
    if (get_busy(0) !== 1'b1 || get_bcd(0) !== 20'h000) begin
      failures++;
      $display("FAIL b2b_restart: got busy=%b bcd=%h required 1/000", get_busy(0), get_bcd(0));
    end
    e = 0;
    while (!get_done(0) && e < 20) begin
      @(negedge clk);
      e++;
    end
    checks++;
    if (e != 3 || get_bcd(0) !== 20'h007) begin
      failures++;
      $display("FAIL b2b_second: got edges=%0d bcd=%h required 3/007", e, get_bcd(0));
    end
  endtask

  task automatic test_reset_mid();
    int pulses; int e; logic [19:0] b; logic o;
    @(negedge clk);
    set_in(0, 1'b1, 16'd255);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0);
    @(negedge clk);                       // digit 0 just written
    checks++;
    if (get_bcd(0) !== 20'h005) begin
      failures++;
      $display("FAIL mid_digit0: got %h required 005", get_bcd(0));
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (get_busy(0) !== 1'b0 || get_bcd(0) !== 20'h0 || get_done(0) !== 1'b0) begin
      failures++;
      $display("FAIL mid_abort: got busy=%b bcd=%h done=%b required 0/000/0", get_busy(0), get_bcd(0), get_done(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL mid_no_done: got %0d active cycles required 0", pulses);
    end
    run_conv(0, 16'd123, e, b, o);
    checks++;
    if (b !== 20'h123 || o !== 1'b0 || e != 3) begin
      failures++;
      $display("FAIL mid_recover: got bcd=%h ovf=%b edges=%0d required 123/0/3", b, o, e);
    end
  endtask

  task automatic test_wide();
    int e; logic [19:0] b; logic o;
    run_conv(2, 16'd65535, e, b, o);
    checks++;
    if (b !== 20'h65535 || o !== 1'b0 || e != 5) begin
      failures++;
      $display("FAIL wide_65535: got bcd=%h ovf=%b edges=%0d required 65535/0/5", b, o, e);
    end
    run_conv(2, 16'd10000, e, b, o);
    checks++;
    if (b !== 20'h10000 || o !== 1'b0) begin
      failures++;
      $display("FAIL wide_10000: got bcd=%h ovf=%b required 10000/0", b, o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
